// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg -- shared ALU op parameters and ID/EX stage types.
//   ALU_OP_WIDTH : width of the operator field carried from decode to the ALU
//   alu_op_e     : ALU opcode encodings
//   stage_state_e: occupancy of the single-entry ID/EX register
//   fwd_hit()    : bypass match rule (write enabled, not x0, same index)
package id_ex_stage_pkg;

  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hard-wired to zero, so a write to it never supplies an operand.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- decode-side and ALU-side handshake bundle of the ID/EX stage.
//   Decode side : in_valid/in_ready, in_operator, in_imm, in_pc,
//                 in_rs1_addr/in_rs2_addr/in_rd_addr, in_rs1_data/in_rs2_data
//   ALU side    : out_valid/out_ready, operator, imm, operand1, operand2,
//                 out_rd_addr, out_pc
//   modport slave  : the ID/EX stage itself
//   modport master : the surrounding pipeline (decode producer + ALU consumer)
interface id_ex_stage_if import id_ex_stage_pkg::*; #(
  parameter int XLEN = 32
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [ALU_OP_WIDTH-1:0] in_operator;
  logic [XLEN-1:0]         in_imm;
  logic [XLEN-1:0]         in_pc;
  logic [4:0]              in_rs1_addr;
  logic [4:0]              in_rs2_addr;
  logic [4:0]              in_rd_addr;
  logic [XLEN-1:0]         in_rs1_data;
  logic [XLEN-1:0]         in_rs2_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [ALU_OP_WIDTH-1:0] operator;
  logic [XLEN-1:0]         imm;
  logic [XLEN-1:0]         operand1;
  logic [XLEN-1:0]         operand2;
  logic [4:0]              out_rd_addr;
  logic [XLEN-1:0]         out_pc;

  modport slave (
    input  in_valid, in_operator, in_imm, in_pc, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, operator, imm, operand1, operand2,
           out_rd_addr, out_pc
  );

  modport master (
    output in_valid, in_operator, in_imm, in_pc, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, operator, imm, operand1, operand2,
           out_rd_addr, out_pc
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux -- operand bypass select for one source register.
//   i_rs, i_rs_data            : source index and register-file read data
//   i_ex_we/i_ex_rd/i_ex_data  : result one stage ahead (highest priority)
//   i_wb_we/i_wb_rd/i_wb_data  : writeback result
//   o_operand                  : resolved operand
// EN=0 turns the mux into a pass-through of the register-file data.
module fwd_mux import id_ex_stage_pkg::*; #(
  parameter int XLEN = 32,
  parameter bit EN   = 1'b1
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic            i_ex_we,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_data,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_operand
);

  generate
    if (EN) begin : g_fwd
      // The younger EX result wins over WB when both target the same register.
      always_comb begin
        o_operand = i_rs_data;
        if (fwd_hit(i_ex_we, i_ex_rd, i_rs)) begin
          o_operand = i_ex_data;
        end else if (fwd_hit(i_wb_we, i_wb_rd, i_rs)) begin
          o_operand = i_wb_data;
        end
      end
    end else begin : g_bypass
      logic w_unused;
      assign w_unused  = ^{i_rs, i_ex_we, i_ex_rd, i_ex_data,
                           i_wb_we, i_wb_rd, i_wb_data};
      assign o_operand = i_rs_data;
    end
  endgenerate

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- single-entry ID/EX pipeline register with operand forwarding.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop the held and the same-cycle incoming instruction
//   fwd_ex_*        : result one stage ahead (we, rd, data)
//   fwd_wb_*        : writeback result (we, rd, data)
//   bus (slave)     : decode-side and ALU-side handshakes, see id_ex_stage_if
//   stall_cnt       : saturating count of cycles with out_valid && !out_ready
// Build option: define ID_EX_FORWARD_EN to enable EX/WB bypass at capture and
// the writeback refresh of held operands while stalled. Without it operands
// come straight from the register file and the fwd_* ports are ignored.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fwd_ex_we,
  input  logic [4:0]        fwd_ex_rd,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_wb_we,
  input  logic [4:0]        fwd_wb_rd,
  input  logic [XLEN-1:0]   fwd_wb_data,
  id_ex_stage_if.slave      bus,
  output logic [15:0]       stall_cnt
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  stage_state_e            r_state, w_state_nxt;
  logic                    w_full, w_in_ready, w_accept, w_stall;
  logic [XLEN-1:0]         w_opnd1_res, w_opnd2_res;

  logic [ALU_OP_WIDTH-1:0] r_op_p1;
  logic [XLEN-1:0]         r_imm_p1, r_pc_p1, r_opnd1_p1, r_opnd2_p1;
  logic [4:0]              r_rd_p1;
  logic [15:0]             r_stall_p1;
`ifdef ID_EX_FORWARD_EN
  logic [4:0]              r_rs1_p1, r_rs2_p1;
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_full     = (r_state == ST_FULL);
  // Accept in the same cycle the held entry drains; always ready under reset.
  assign w_in_ready = rst || !w_full || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !flush && !rst;
  assign w_stall    = w_full && !bus.out_ready;

  fwd_mux #(.XLEN(XLEN), .EN(FWD_EN)) u_fwd_rs1 (
    .i_rs      (bus.in_rs1_addr),
    .i_rs_data (bus.in_rs1_data),
    .i_ex_we   (fwd_ex_we),
    .i_ex_rd   (fwd_ex_rd),
    .i_ex_data (fwd_ex_data),
    .i_wb_we   (fwd_wb_we),
    .i_wb_rd   (fwd_wb_rd),
    .i_wb_data (fwd_wb_data),
    .o_operand (w_opnd1_res)
  );

  fwd_mux #(.XLEN(XLEN), .EN(FWD_EN)) u_fwd_rs2 (
    .i_rs      (bus.in_rs2_addr),
    .i_rs_data (bus.in_rs2_data),
    .i_ex_we   (fwd_ex_we),
    .i_ex_rd   (fwd_ex_rd),
    .i_ex_data (fwd_ex_data),
    .i_wb_we   (fwd_wb_we),
    .i_wb_rd   (fwd_wb_rd),
    .i_wb_data (fwd_wb_data),
    .o_operand (w_opnd2_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush outranks every handshake; back-to-back accept keeps the stage FULL.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (w_full && bus.out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // ---- stage p1: captured instruction ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_p1    <= '0;
      r_imm_p1   <= '0;
      r_pc_p1    <= '0;
      r_rd_p1    <= '0;
      r_opnd1_p1 <= '0;
      r_opnd2_p1 <= '0;
`ifdef ID_EX_FORWARD_EN
      r_rs1_p1   <= '0;
      r_rs2_p1   <= '0;
`endif
    end else if (w_accept) begin
      r_op_p1    <= bus.in_operator;
      r_imm_p1   <= bus.in_imm;
      r_pc_p1    <= bus.in_pc;
      r_rd_p1    <= bus.in_rd_addr;
      r_opnd1_p1 <= w_opnd1_res;
      r_opnd2_p1 <= w_opnd2_res;
`ifdef ID_EX_FORWARD_EN
      r_rs1_p1   <= bus.in_rs1_addr;
      r_rs2_p1   <= bus.in_rs2_addr;
`endif
    end
`ifdef ID_EX_FORWARD_EN
    // A producer retiring while we wait would otherwise leave a stale operand.
    else if (w_stall) begin
      if (fwd_hit(fwd_wb_we, fwd_wb_rd, r_rs1_p1)) r_opnd1_p1 <= fwd_wb_data;
      if (fwd_hit(fwd_wb_we, fwd_wb_rd, r_rs2_p1)) r_opnd2_p1 <= fwd_wb_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_p1 <= '0;
    end else if (w_stall) begin
      r_stall_p1 <= sat_inc16(r_stall_p1);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_full;
  assign bus.operator    = r_op_p1;
  assign bus.imm         = r_imm_p1;
  assign bus.operand1    = r_opnd1_p1;
  assign bus.operand2    = r_opnd2_p1;
  assign bus.out_rd_addr = r_rd_p1;
  assign bus.out_pc      = r_pc_p1;
  assign stall_cnt       = r_stall_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- self-checking bench for id_ex_stage: directed scenarios
// followed by randomized traffic compared against a transaction-level model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              fwd_ex_we, fwd_wb_we;
  logic [4:0]        fwd_ex_rd, fwd_wb_rd;
  logic [XLEN-1:0]   fwd_ex_data, fwd_wb_data;
  logic [15:0]       stall_cnt;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fwd_ex_we   (fwd_ex_we),
    .fwd_ex_rd   (fwd_ex_rd),
    .fwd_ex_data (fwd_ex_data),
    .fwd_wb_we   (fwd_wb_we),
    .fwd_wb_rd   (fwd_wb_rd),
    .fwd_wb_data (fwd_wb_data),
    .bus         (bus),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the instruction currently held by the stage.
  bit              m_valid;
  logic [3:0]      m_op;
  logic [XLEN-1:0] m_imm, m_pc, m_op1, m_op2;
  logic [4:0]      m_rd, m_rs1, m_rs2;
  int              m_stall;

  function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (FWD && fwd_ex_we && rs != 5'd0 && fwd_ex_rd == rs) return fwd_ex_data;
    if (FWD && fwd_wb_we && rs != 5'd0 && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  // Inputs are already set; advance one clock and compare against the model.
  task automatic cycle();
    bit rdy, stalled, was_rst;
    #1;
    rdy = rst || !m_valid || bus.out_ready;
    check("in_ready", bus.in_ready, rdy);
    stalled = m_valid && !bus.out_ready;
    was_rst = rst;
    if (rst) begin
      m_valid = 0; m_op = 0; m_imm = 0; m_pc = 0; m_op1 = 0; m_op2 = 0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_stall = 0;
    end else begin
      if (stalled && m_stall < 65535) m_stall++;
      if (flush) begin
        m_valid = 0;
      end else if (bus.in_valid && rdy) begin
        m_valid = 1;
        m_op  = bus.in_operator;  m_imm = bus.in_imm;  m_pc = bus.in_pc;
        m_rd  = bus.in_rd_addr;   m_rs1 = bus.in_rs1_addr; m_rs2 = bus.in_rs2_addr;
        m_op1 = resolve(bus.in_rs1_addr, bus.in_rs1_data);
        m_op2 = resolve(bus.in_rs2_addr, bus.in_rs2_data);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end else if (stalled && FWD && fwd_wb_we && fwd_wb_rd != 5'd0) begin
        if (fwd_wb_rd == m_rs1) m_op1 = fwd_wb_data;
        if (fwd_wb_rd == m_rs2) m_op2 = fwd_wb_data;
      end
    end
    @(posedge clk); #1;
    check("out_valid", bus.out_valid, m_valid);
    check("stall_cnt", stall_cnt, m_stall[15:0]);
    if (m_valid || was_rst) begin
      check("operator", bus.operator, m_op);
      check("imm", bus.imm, m_imm);
      check("operand1", bus.operand1, m_op1);
      check("operand2", bus.operand2, m_op2);
      check("out_rd", bus.out_rd_addr, m_rd);
      check("out_pc", bus.out_pc, m_pc);
    end
  endtask

  task automatic set_idle();
    rst = 0; flush = 0;
    fwd_ex_we = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    bus.in_valid = 0; bus.out_ready = 1;
    bus.in_operator = 0; bus.in_imm = 0; bus.in_pc = 0; bus.in_rd_addr = 0;
    bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [3:0] op, input logic [31:0] pc);
    bus.in_valid = 1;
    bus.in_rs1_addr = rs1; bus.in_rs1_data = d1;
    bus.in_rs2_addr = rs2; bus.in_rs2_data = d2;
    bus.in_operator = op;  bus.in_pc = pc;
    bus.in_imm = pc ^ 32'h0000_0F0F; bus.in_rd_addr = 5'd9;
  endtask

  initial begin
    set_idle();
    m_valid = 0; m_stall = 0;

    // Reset
    rst = 1; bus.in_valid = 1; cycle(); cycle();
    check("rst_stall", stall_cnt, 16'd0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    set_idle();

    // Single accept
    set_instr(5'd1, 32'd5, 5'd2, 32'd7, 4'd3, 32'h40);
    cycle();
    check("acc_valid", bus.out_valid, 1'b1);
    check("acc_op1", bus.operand1, 32'd5);
    check("acc_op2", bus.operand2, 32'd7);
    check("acc_oper", bus.operator, 4'd3);
    bus.in_valid = 0; cycle();

    // Forwarding priority and x0
    set_instr(5'd4, 32'h11, 5'd5, 32'h12, 4'd1, 32'h44);
    fwd_ex_we = 1; fwd_ex_rd = 5'd4; fwd_ex_data = 32'hAA;
    fwd_wb_we = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hBB;
    cycle();
    check("fwd_pri", bus.operand1, FWD ? 32'hAA : 32'h11);
    set_instr(5'd0, 32'h0, 5'd5, 32'h12, 4'd1, 32'h48);
    fwd_ex_rd = 5'd0; fwd_ex_data = 32'hCC; fwd_wb_rd = 5'd0;
    cycle();
    check("fwd_x0", bus.operand1, 32'd0);
    set_idle(); cycle();

    // Stall with writeback refresh
    rst = 1; cycle(); rst = 0;
    set_instr(5'd3, 32'h31, 5'd6, 32'h22, 4'd2, 32'h80);
    cycle();
    set_instr(5'd7, 32'h77, 5'd8, 32'h88, 4'd4, 32'h84);
    bus.out_ready = 0;
    cycle();
    check("stall_rdy1", bus.in_ready, 1'b0);
    fwd_wb_we = 1; fwd_wb_rd = 5'd6; fwd_wb_data = 32'h55;
    cycle();
    check("stall_rdy2", bus.in_ready, 1'b0);
    check("refresh_op2", bus.operand2, FWD ? 32'h55 : 32'h22);
    fwd_wb_we = 0;
    cycle();
    check("stall_rdy3", bus.in_ready, 1'b0);
    check("stall_cnt3", stall_cnt, 16'd3);
    check("stall_pc", bus.out_pc, 32'h80);
    check("stall_op1", bus.operand1, 32'h31);
    set_idle(); cycle();

    // Back-to-back
    for (int i = 0; i < 4; i++) begin
      set_instr(5'd1, 32'(i), 5'd2, 32'(i + 10), 4'd5, 32'h100 + 32'(4 * i));
      cycle();
      check("b2b_valid", bus.out_valid, 1'b1);
      check("b2b_pc", bus.out_pc, 32'h100 + 32'(4 * i));
    end
    set_idle(); cycle();
    check("b2b_drain", bus.out_valid, 1'b0);

    // Flush and mid-stall reset
    set_instr(5'd1, 32'h1, 5'd2, 32'h2, 4'd6, 32'h200);
    cycle();
    flush = 1; bus.in_pc = 32'h204; cycle(); flush = 0;
    check("flush_valid", bus.out_valid, 1'b0);
    cycle();
    bus.in_valid = 0; bus.out_ready = 0; cycle();
    rst = 1; cycle(); rst = 0;
    check("rst_mid_valid", bus.out_valid, 1'b0);
    check("rst_mid_stall", stall_cnt, 16'd0);
    check("rst_mid_pc", bus.out_pc, 32'd0);
    check("rst_mid_op2", bus.operand2, 32'd0);
    set_idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      bus.in_valid  = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_rs1_addr = 5'($urandom_range(0, 7));
      bus.in_rs2_addr = 5'($urandom_range(0, 7));
      bus.in_rd_addr  = 5'($urandom_range(0, 31));
      bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
      bus.in_imm = $urandom; bus.in_pc = $urandom;
      bus.in_operator = 4'($urandom_range(0, 15));
      fwd_ex_we = $urandom_range(0, 1); fwd_ex_rd = 5'($urandom_range(0, 7)); fwd_ex_data = $urandom;
      fwd_wb_we = $urandom_range(0, 1); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
      cycle();
    end

    // Stall counter saturation
    set_idle();
    rst = 1; cycle(); rst = 0;
    set_instr(5'd1, 32'h1, 5'd2, 32'h2, 4'd7, 32'h300);
    cycle();
    bus.in_valid = 0; bus.out_ready = 0;
    repeat (65540) @(posedge clk);
    #1;
    m_stall = (m_stall + 65540 > 65535) ? 65535 : m_stall + 65540;
    check("stall_sat", stall_cnt, 16'hFFFF);
    cycle();
    check("stall_hold", stall_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
